// File: rtl/sysbus_pkg.sv
// Shared definitions for the serial slave-output port and its master-side peer:
// state encoding, default widths and small helpers used by both ends.
package sysbus_pkg;

    // Default bits per serial byte.
    localparam int SYSBUS_BYTE_W  = 8;
    // Default width of the burst length field and the byte counter.
    localparam int SYSBUS_BURST_W = 12;

    // Response sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_OFFER = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } sysbus_state_e;

    // Width needed to index one bit of a byte of the given width.
    function automatic int idx_width(input int byte_w);
        int w;
        w = 1;
        while ((1 << w) < byte_w) begin
            w = w + 1;
        end
        return w;
    endfunction

    // True when the state is one in which a byte is being put on the wire.
    function automatic logic is_sending(input sysbus_state_e st);
        logic r;
        case (st)
            ST_OFFER: r = 1'b1;
            ST_SHIFT: r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_skid_buf.sv
// One-entry prefetch register with valid/ready handshakes on both sides.
// The entry accepts only when empty and releases only when full, so a push
// and a pop never fall in the same cycle.
module byte_skid_buf
    import sysbus_pkg::*;
#(
    parameter int W = SYSBUS_BYTE_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full_r;
    logic [W-1:0] data_r;

    // Entry occupancy and payload, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
        end else if (in_valid && !full_r) begin
            full_r <= 1'b1;
            data_r <= in_data;
        end else if (out_ready && full_r) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign in_ready  = !full_r;
    assign out_valid = full_r;
    assign out_data  = data_r;

endmodule

// File: rtl/slave_out.sv
// Serial read-response sender: fetches burst_num+1 bytes from slave memory
// and shifts each out LSB first, offering bit 0 with slave_valid until the
// master is ready, then streaming the remaining bits unconditionally.
// All outputs are decoded from registered state only.
module slave_out
    import sysbus_pkg::*;
#(
    parameter int BYTE_W  = SYSBUS_BYTE_W,
    parameter int BURST_W = SYSBUS_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BURST_W-1:0] burst_num,
    input  logic [BYTE_W-1:0]  data_in,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic               master_ready,
    output logic               slave_valid,
    output logic               tx_data,
    output logic               busy,
    output logic               resp_done
);

    localparam int IDX_W = idx_width(BYTE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_W - 1);

    sysbus_state_e      state_r, state_n;
    logic [BYTE_W-1:0]  shift_r, shift_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [BURST_W-1:0] cnt_r, cnt_n;
    logic [BURST_W-1:0] burst_r, burst_n;

    logic               more_s;
    logic               prefetch_ready_s;
    logic               pop_s;
    logic               skid_in_ready_s;
    logic               skid_valid_s;
    logic [BYTE_W-1:0]  skid_data_s;

    // A further byte is still owed after the one currently being sent.
    assign more_s = (cnt_r != burst_r);

    byte_skid_buf #(
        .W(BYTE_W)
    ) u_prefetch (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (data_in_valid && prefetch_ready_s),
        .in_ready  (skid_in_ready_s),
        .in_data   (data_in),
        .out_valid (skid_valid_s),
        .out_ready (pop_s),
        .out_data  (skid_data_s)
    );

    // Output decode from the registered state, counter and prefetch occupancy.
    always_comb begin
        slave_valid      = 1'b0;
        tx_data          = 1'b0;
        busy             = 1'b0;
        resp_done        = 1'b0;
        data_in_ready    = 1'b0;
        prefetch_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_FETCH: begin
                busy          = 1'b1;
                // A byte already parked in the prefetch entry is used first.
                data_in_ready = !skid_valid_s;
            end
            ST_OFFER: begin
                busy             = 1'b1;
                slave_valid      = 1'b1;
                tx_data          = shift_r[0];
                prefetch_ready_s = skid_in_ready_s && more_s;
                data_in_ready    = prefetch_ready_s;
            end
            ST_SHIFT: begin
                busy             = 1'b1;
                tx_data          = shift_r[idx_r];
                prefetch_ready_s = skid_in_ready_s && more_s;
                data_in_ready    = prefetch_ready_s;
            end
            ST_DONE: begin
                busy      = 1'b1;
                resp_done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Next-state, shift register, bit index and byte counter updates.
    always_comb begin
        state_n = state_r;
        shift_n = shift_r;
        idx_n   = idx_r;
        cnt_n   = cnt_r;
        burst_n = burst_r;
        pop_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    burst_n = burst_num;
                    cnt_n   = {BURST_W{1'b0}};
                    idx_n   = {IDX_W{1'b0}};
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (skid_valid_s) begin
                    pop_s   = 1'b1;
                    shift_n = skid_data_s;
                    idx_n   = {IDX_W{1'b0}};
                    state_n = ST_OFFER;
                end else if (data_in_valid) begin
                    shift_n = data_in;
                    idx_n   = {IDX_W{1'b0}};
                    state_n = ST_OFFER;
                end else begin
                    state_n = ST_FETCH;
                end
            end
            ST_OFFER: begin
                if (master_ready) begin
                    idx_n   = {{(IDX_W-1){1'b0}}, 1'b1};
                    state_n = ST_SHIFT;
                end else begin
                    state_n = ST_OFFER;
                end
            end
            ST_SHIFT: begin
                if (idx_r == LAST_IDX) begin
                    if (!more_s) begin
                        state_n = ST_DONE;
                    end else begin
                        cnt_n = cnt_r + BURST_W'(1);
                        if (skid_valid_s) begin
                            pop_s   = 1'b1;
                            shift_n = skid_data_s;
                            idx_n   = {IDX_W{1'b0}};
                            state_n = ST_OFFER;
                        end else begin
                            state_n = ST_FETCH;
                        end
                    end
                end else begin
                    idx_n = idx_r + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register; reset wins over everything, including a start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            shift_r <= {BYTE_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            cnt_r   <= {BURST_W{1'b0}};
            burst_r <= {BURST_W{1'b0}};
        end else begin
            state_r <= state_n;
            shift_r <= shift_n;
            idx_r   <= idx_n;
            cnt_r   <= cnt_n;
            burst_r <= burst_n;
        end
    end

endmodule

// File: tb/tb_slave_out.sv
// Directed bench for slave_out: a transaction-level model predicts every
// output each cycle, a collector reassembles serial bytes, and literal
// expectations pin latency, spacing and reset behaviour.
module tb_slave_out;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] burst_num;
    logic [7:0]  data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        master_ready;
    logic        slave_valid;
    logic        tx_data;
    logic        busy;
    logic        resp_done;

    int n_chk = 0;
    int n_err = 0;

    // stimulus source, owned by the test thread except src_idx/gap_left
    logic [7:0] src [0:4199];
    int src_n = 0, src_gen = 0, gap_at = -1, gap_len = 0;
    int src_idx = 0, gap_left = 0, seen_gen = 0;

    // collector results
    int         cyc = 0;
    logic [7:0] rx_q [$];
    int         sv_cyc [$];
    int         done_n = 0, done_cyc = 0;

    always #5 clk = ~clk;

    slave_out dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .burst_num     (burst_num),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .master_ready  (master_ready),
        .slave_valid   (slave_valid),
        .tx_data       (tx_data),
        .busy          (busy),
        .resp_done     (resp_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Memory-side source: presents src[] bytes, advancing on each accepted one.
    initial begin
        logic hs;
        data_in = 8'h00;
        data_in_valid = 1'b0;
        forever begin
            @(negedge clk);
            hs = data_in_valid && data_in_ready && reset;
            @(posedge clk);
            #2;
            if (src_gen != seen_gen) begin
                seen_gen = src_gen;
                src_idx = 0;
                gap_left = 0;
            end else if (hs) begin
                src_idx++;
                if (src_idx == gap_at) gap_left = gap_len;
            end else if (gap_left > 0) begin
                gap_left--;
            end
            if (src_idx < src_n && gap_left == 0) begin
                data_in_valid = 1'b1;
                data_in = src[src_idx];
            end else begin
                data_in_valid = 1'b0;
                data_in = 8'h00;
            end
        end
    end

    // Collector: rebuilds bytes from slave_valid + 8 serial bits, logs pulses.
    initial begin
        logic [7:0] b;
        int pos;
        bit on;
        on = 0; pos = 0; b = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                on = 0;
            end else begin
                if (slave_valid) begin
                    b = 8'h00;
                    b[0] = tx_data;
                    pos = 1;
                    on = 1;
                    sv_cyc.push_back(cyc);
                end else if (on) begin
                    b[pos] = tx_data;
                    pos++;
                    if (pos == 8) begin
                        rx_q.push_back(b);
                        on = 0;
                    end
                end
                if (resp_done) begin
                    done_n++;
                    done_cyc = cyc;
                end
            end
        end
    end

    // Transaction model: mode 0 idle, 1 waiting for a byte, 2 sending bit m_bit
    // (bit 0 = offered), 3 done. Compared against the DUT every cycle.
    initial begin
        int m_mode, m_bit, m_total, m_sent, m_fetched;
        logic [7:0] m_cur;
        logic [7:0] m_q [$];
        logic e_busy, e_sv, e_tx, e_done, e_rdy, had_q;
        m_mode = 0; m_bit = 0; m_total = 0; m_sent = 0; m_fetched = 0; m_cur = 8'h00;
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_busy = (m_mode != 0);
            e_sv   = (m_mode == 2) && (m_bit == 0);
            e_tx   = (m_mode == 2) ? m_cur[m_bit] : 1'b0;
            e_done = (m_mode == 3);
            if (m_mode == 1)      e_rdy = (m_q.size() == 0);
            else if (m_mode == 2) e_rdy = (m_q.size() == 0) && (m_fetched < m_total);
            else                  e_rdy = 1'b0;
            chk("busy", 32'(busy), 32'(e_busy));
            chk("slave_valid", 32'(slave_valid), 32'(e_sv));
            chk("tx_data", 32'(tx_data), 32'(e_tx));
            chk("resp_done", 32'(resp_done), 32'(e_done));
            chk("data_in_ready", 32'(data_in_ready), 32'(e_rdy));
            if (!reset) begin
                m_mode = 0; m_bit = 0; m_q.delete();
            end else begin
                case (m_mode)
                    0: if (start) begin
                        m_total = int'(burst_num) + 1; m_sent = 1; m_fetched = 0; m_mode = 1;
                    end
                    1: if (m_q.size() != 0) begin
                        m_cur = m_q.pop_front(); m_bit = 0; m_mode = 2;
                    end else if (data_in_valid) begin
                        m_cur = data_in; m_fetched++; m_bit = 0; m_mode = 2;
                    end
                    2: begin
                        had_q = (m_q.size() != 0);
                        if (m_bit == 0) begin
                            if (master_ready) m_bit = 1;
                        end else if (m_bit < 7) begin
                            m_bit++;
                        end else if (m_sent == m_total) begin
                            m_mode = 3;
                        end else begin
                            m_sent++;
                            if (had_q) begin
                                m_cur = m_q.pop_front(); m_bit = 0;
                            end else begin
                                m_mode = 1;
                            end
                        end
                        if (e_rdy && data_in_valid) begin
                            m_q.push_back(data_in); m_fetched++;
                        end
                    end
                    3: m_mode = 0;
                    default: m_mode = 0;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_src(input int n, input int g_at, input int g_len);
        src_n = n; gap_at = g_at; gap_len = g_len; src_gen++;
    endtask

    task automatic pulse_start(input logic [11:0] b);
        burst_num = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        bit got;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_n > base) begin
                got = 1;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
    endtask

    task automatic check_rx(input string name, input int base, input int n);
        chk({name, "_nbytes"}, 32'(rx_q.size() - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size()) chk({name, "_byte"}, 32'(rx_q[base + i]), 32'(src[i]));
        end
    endtask

    initial begin
        int rb, db, sb;
        bit got;
        logic [9:0] lit_tx, lit_sv, lit_done;
        reset = 1'b0; start = 1'b0; burst_num = 12'd0; master_ready = 1'b1;
        step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sv", 32'(slave_valid), 32'd0);
        chk("rst_rdy", 32'(data_in_ready), 32'd0);
        step();
        reset = 1'b1;
        step();

        // single byte A5: exact cycle-by-cycle trace after start
        src[0] = 8'hA5;
        load_src(1, -1, 0);
        step();
        rb = rx_q.size(); db = done_n;
        pulse_start(12'd0);
        lit_tx = 10'b0101001010; lit_sv = 10'b0000000010; lit_done = 10'b1000000000;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("a5_tx", 32'(tx_data), 32'(lit_tx[k-1]));
            chk("a5_sv", 32'(slave_valid), 32'(lit_sv[k-1]));
            chk("a5_done", 32'(resp_done), 32'(lit_done[k-1]));
            step();
        end
        check_rx("a5", rb, 1);
        chk("a5_one_done", 32'(done_n - db), 32'd1);

        // three bytes back-to-back with data always valid
        src[0] = 8'h01; src[1] = 8'h80; src[2] = 8'hFF; src[3] = 8'h99; src[4] = 8'h66;
        load_src(5, -1, 0);
        step();
        rb = rx_q.size(); db = done_n; sb = sv_cyc.size();
        pulse_start(12'd2);
        wait_done("b2b", db, 60);
        check_rx("b2b", rb, 3);
        if (sv_cyc.size() >= sb + 3) begin
            chk("b2b_gap1", 32'(sv_cyc[sb+1] - sv_cyc[sb]), 32'd8);
            chk("b2b_gap2", 32'(sv_cyc[sb+2] - sv_cyc[sb+1]), 32'd8);
            chk("b2b_done_at", 32'(done_cyc - sv_cyc[sb]), 32'd24);
        end else begin
            chk("b2b_offers", 32'(sv_cyc.size() - sb), 32'd3);
        end
        chk("b2b_taken", 32'(src_idx), 32'd3);

        // master stalls the offer for five cycles
        src[0] = 8'hC3;
        load_src(1, -1, 0);
        master_ready = 1'b0;
        step();
        rb = rx_q.size(); db = done_n;
        pulse_start(12'd0);
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (slave_valid) begin
                got = 1;
                break;
            end
        end
        chk("stall_offer_seen", 32'(got), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_sv", 32'(slave_valid), 32'd1);
            chk("stall_tx", 32'(tx_data), 32'd1);
            step();
            if (i < 4) @(negedge clk);
        end
        master_ready = 1'b1;
        wait_done("stall", db, 40);
        check_rx("stall", rb, 1);

        // second byte arrives late: sender waits in FETCH
        src[0] = 8'h11; src[1] = 8'hE7;
        load_src(2, 1, 12);
        step();
        rb = rx_q.size(); db = done_n; sb = sv_cyc.size();
        pulse_start(12'd1);
        wait_done("late", db, 80);
        check_rx("late", rb, 2);
        if (sv_cyc.size() >= sb + 2) chk("late_gap", 32'(sv_cyc[sb+1] - sv_cyc[sb]), 32'd13);
        else chk("late_offers", 32'(sv_cyc.size() - sb), 32'd2);

        // reset at bit 4 of byte 2 of a 4-byte burst, then a clean burst
        src[0] = 8'hAA; src[1] = 8'h55; src[2] = 8'hF0; src[3] = 8'h0F;
        load_src(4, -1, 0);
        step();
        db = done_n; sb = sv_cyc.size();
        pulse_start(12'd3);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sv_cyc.size() >= sb + 2) begin
                got = 1;
                break;
            end
        end
        chk("abort_second_offer", 32'(got), 32'd1);
        repeat (3) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sv", 32'(slave_valid), 32'd0);
        chk("abort_tx", 32'(tx_data), 32'd0);
        chk("abort_rdy", 32'(data_in_ready), 32'd0);
        repeat (3) step();
        chk("abort_no_done", 32'(done_n - db), 32'd0);
        src[0] = 8'h3E; src[1] = 8'hC1; src[2] = 8'h7B; src[3] = 8'h84;
        load_src(4, -1, 0);
        step();
        rb = rx_q.size(); db = done_n;
        pulse_start(12'd3);
        wait_done("rerun", db, 80);
        check_rx("rerun", rb, 4);

        // start during a burst and start with reset low are both ignored
        src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'h56; src[3] = 8'h78;
        src[4] = 8'h9A; src[5] = 8'hBC;
        load_src(6, -1, 0);
        step();
        rb = rx_q.size(); db = done_n;
        pulse_start(12'd3);
        repeat (5) step();
        pulse_start(12'd0);
        wait_done("restart", db, 80);
        check_rx("restart", rb, 4);
        chk("restart_taken", 32'(src_idx), 32'd4);
        chk("restart_one_done", 32'(done_n - db), 32'd1);
        reset = 1'b0; start = 1'b1; burst_num = 12'd2;
        step();
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", 32'(busy), 32'd0);
        step();
        @(negedge clk);
        chk("rst_start_busy2", 32'(busy), 32'd0);
        step();

        // largest burst: 4096 bytes, counter must not wrap
        for (int i = 0; i < 4100; i++) src[i] = 8'((i * 7 + 3) ^ (i >> 8));
        load_src(4100, -1, 0);
        step();
        rb = rx_q.size(); db = done_n;
        pulse_start(12'hFFF);
        wait_done("max", db, 40000);
        check_rx("max", rb, 4096);
        chk("max_taken", 32'(src_idx), 32'd4096);
        chk("max_one_done", 32'(done_n - db), 32'd1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
